// File: rtl/streamer_pkg.sv
// Shared types and default widths for the sensor sample streamer.
package streamer_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;
  localparam int PACE_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } stream_state_e;
endpackage

// File: rtl/sample_fifo.sv
// Circular sample buffer; head entry is visible on rdata without a read cycle.
// overflow is a per-cycle strobe for a rejected push; the owner keeps it sticky.
module sample_fifo
  import streamer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic              overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push, pop;

  // full is taken from the registered count, so a pop cannot make room for a same-cycle push
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign push     = wr && !full;
  assign pop      = rd && !empty;
  assign overflow = wr && full;
  assign rdata    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/sensor_sample_streamer.sv
// Paces buffered sensor samples onto data_input/data_valid and captures anomalies.
// Define STREAMER_ANOMALY_CNT_EN to add the saturating anomaly_cnt output.
module sensor_sample_streamer
  import streamer_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
`ifdef STREAMER_ANOMALY_CNT_EN
  , parameter int CNT_W     = DEF_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_wr,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [DATA_W-1:0] data_input,
  output logic              data_valid,
  input  logic              anomaly_detected,
  output logic              anomaly_flag,
  output logic [DATA_W-1:0] anomaly_sample,
`ifdef STREAMER_ANOMALY_CNT_EN
  output logic [CNT_W-1:0]  anomaly_cnt,
`endif
  input  logic              clear
);
  stream_state_e     state_q, state_d;
  logic [PACE_W-1:0] hold_q, hold_d, gap_q, gap_d;
  logic [DATA_W-1:0] data_q, data_d, asample_q, asample_d;
  logic              valid_q, valid_d, ovf_q, ovf_d, flag_q, flag_d;
  logic              pop, hit;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_ovf;

  sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr       (sample_wr),
    .wdata    (sample_in),
    .rd       (pop),
    .rdata    (fifo_rdata),
    .full     (full),
    .empty    (empty),
    .overflow (fifo_ovf)
  );

  assign hit = anomaly_detected && (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    data_d  = data_q;
    valid_d = valid_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !empty) begin
          pop     = 1'b1;
          data_d  = fifo_rdata;
          valid_d = 1'b1;
          hold_d  = PACE_W'(HOLD_CYCLES - 1);
          state_d = SEND;
        end
      end
      SEND: begin
        if (hold_q != '0) begin
          hold_d = hold_q - PACE_W'(1);
        end else begin
          valid_d = 1'b0;
          if (GAP_CYCLES > 0) begin
            gap_d   = PACE_W'(GAP_CYCLES - 1);
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - PACE_W'(1);
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // clear wins over a same-cycle anomaly or rejected push
  always_comb begin
    ovf_d     = ovf_q;
    flag_d    = flag_q;
    asample_d = asample_q;
    if (clear) begin
      ovf_d     = 1'b0;
      flag_d    = 1'b0;
      asample_d = '0;
    end else begin
      if (fifo_ovf) ovf_d = 1'b1;
      if (hit) begin
        flag_d    = 1'b1;
        asample_d = data_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      gap_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      flag_q    <= 1'b0;
      asample_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      flag_q    <= flag_d;
      asample_q <= asample_d;
    end
  end

`ifdef STREAMER_ANOMALY_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                  cnt_d = '0;
    else if (hit && ~&cnt_q)    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign anomaly_cnt = cnt_q;
`endif

  assign data_input     = data_q;
  assign data_valid     = valid_q;
  assign overflow       = ovf_q;
  assign anomaly_flag   = flag_q;
  assign anomaly_sample = asample_q;
endmodule

// File: tb/tb_sensor_sample_streamer.sv
// Directed bench for sensor_sample_streamer: vector table for pacing, hand sequences for corners.
`timescale 1ns/1ps
module tb_sensor_sample_streamer;
  logic       clk = 1'b0, reset = 1'b0, enable = 1'b0, sample_wr = 1'b0;
  logic       anomaly_detected = 1'b0, clear = 1'b0;
  logic [7:0] sample_in = 8'h00;
  logic       full, empty, overflow, data_valid, anomaly_flag;
  logic [7:0] data_input, anomaly_sample;
  int         checks = 0, errors = 0;
`ifdef STREAMER_ANOMALY_CNT_EN
  logic [1:0] anomaly_cnt;
`endif

  sensor_sample_streamer #(
    .DATA_W(8), .FIFO_DEPTH(8), .HOLD_CYCLES(2), .GAP_CYCLES(1)
`ifdef STREAMER_ANOMALY_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_in(sample_in), .sample_wr(sample_wr),
    .full(full), .empty(empty), .overflow(overflow), .data_input(data_input),
    .data_valid(data_valid), .anomaly_detected(anomaly_detected), .anomaly_flag(anomaly_flag),
    .anomaly_sample(anomaly_sample),
`ifdef STREAMER_ANOMALY_CNT_EN
    .anomaly_cnt(anomaly_cnt),
`endif
    .clear(clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
  } vec_t;
  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; sample_wr = 1'b0; sample_in = 8'h00;
    anomaly_detected = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (data_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok, seen, prev;
    int got;

    // rows: push, data, expected {valid, data_input, empty} after the edge
    tbl[0]  = '{1'b1, 8'hAB, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 8'hAB, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 8'hAB, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'hAB, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'hAB, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'hAB, 1'b1};
    tbl[6]  = '{1'b1, 8'hAB, 1'b0, 8'hAB, 1'b0};
    tbl[7]  = '{1'b1, 8'h23, 1'b1, 8'hAB, 1'b0};
    tbl[8]  = '{1'b1, 8'hAB, 1'b1, 8'hAB, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'hAB, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 8'hAB, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 8'h23, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 8'h23, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h23, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h23, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b1, 8'hAB, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b1, 8'hAB, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 8'hAB, 1'b1};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 8'hAB, 1'b1};

    // reset state
    do_reset();
    #1;
    check("rst_valid", data_valid, 0);
    check("rst_data", data_input, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_flag", anomaly_flag, 0);
    check("rst_asample", anomaly_sample, 0);

    // single sample then back-to-back pacing
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      enable = 1'b1; sample_wr = tbl[i].wr; sample_in = tbl[i].din;
      tick();
      check($sformatf("vec%0d", i), {data_valid, data_input, empty}, {tbl[i].ev, tbl[i].ed, tbl[i].ee});
    end

    // overflow: 9 pushes into an 8-deep buffer while stalled
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sample_wr = 1'b1; sample_in = 8'h10 + 8'(i);
      tick();
      if (i == 7) begin
        check("ovf_full8", full, 1);
        check("ovf_not_yet", overflow, 0);
      end
      if (i == 8) check("ovf_set", overflow, 1);
    end
    @(negedge clk);
    sample_wr = 1'b0; clear = 1'b1;
    tick();
    check("ovf_clear", overflow, 0);
    check("ovf_still_full", full, 1);
    @(negedge clk);
    clear = 1'b0; enable = 1'b1;
    got = 0; prev = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (data_valid && !prev) begin
        if (got < 8) check($sformatf("ovf_drain%0d", got), data_input, 8'h10 + 8'(got));
        got++;
      end
      prev = data_valid;
    end
    check("ovf_drain_count", got, 8);
    check("ovf_empty_end", empty, 1);

    // anomaly capture and clear priority
    do_reset();
    @(negedge clk);
    enable = 1'b1; sample_wr = 1'b1; sample_in = 8'hFF;
    @(negedge clk);
    sample_wr = 1'b0;
    wait_valid(ok);
    check("anom_wait_valid", ok, 1);
    check("anom_data", data_input, 8'hFF);
    @(negedge clk);
    anomaly_detected = 1'b1;
    tick();
    check("anom_flag", anomaly_flag, 1);
    check("anom_sample", anomaly_sample, 8'hFF);
`ifdef STREAMER_ANOMALY_CNT_EN
    check("anom_cnt1", anomaly_cnt, 1);
`endif
    @(negedge clk);
    clear = 1'b1;
    tick();
    check("anom_clr_flag", anomaly_flag, 0);
    check("anom_clr_sample", anomaly_sample, 0);
`ifdef STREAMER_ANOMALY_CNT_EN
    check("anom_clr_cnt", anomaly_cnt, 0);
`endif
    @(negedge clk);
    clear = 1'b0; anomaly_detected = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    anomaly_detected = 1'b1;
    repeat (3) tick();
    check("anom_idle_ignored", anomaly_flag, 0);
    @(negedge clk);
    anomaly_detected = 1'b0;

    // asynchronous reset in the middle of a sample
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample_wr = 1'b1; sample_in = (i == 0) ? 8'hAB : 8'h11 * 8'(i);
    end
    @(negedge clk);
    sample_wr = 1'b0; enable = 1'b1;
    wait_valid(ok);
    check("rst_mid_wait_valid", ok, 1);
    check("rst_mid_data", data_input, 8'hAB);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_valid_drop", data_valid, 0);
    check("rst_mid_empty", empty, 1);
    #4 reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (data_valid) seen = 1'b1;
    end
    check("rst_mid_no_more", seen, 0);

`ifdef STREAMER_ANOMALY_CNT_EN
    // saturation at CNT_W=2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample_wr = 1'b1; sample_in = 8'h50 + 8'(i);
    end
    @(negedge clk);
    sample_wr = 1'b0; enable = 1'b1; anomaly_detected = 1'b1;
    repeat (25) tick();
    check("sat_cnt", anomaly_cnt, 3);
    @(negedge clk);
    anomaly_detected = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sensor_sample_streamer.md
Name: sensor_sample_streamer

Overview:
- Producer side of the i_tree sample interface: buffers raw 8-bit sensor samples and presents them one at a time on data_input/data_valid at a programmable pace.
- Watches the returned anomaly_detected and reports a sticky flag, the last flagged sample and, optionally, an anomaly count.
- Sits between the sensor capture logic and i_tree in the anomaly-detection datapath.

Parameters:
- DATA_W, 8, sample width; must match the i_tree data_input width.
- FIFO_DEPTH, 8, sample buffer entries; power of two, 2..64.
- HOLD_CYCLES, 2, cycles data_valid is held high per sample; range 1..15.
- GAP_CYCLES, 1, idle cycles with data_valid low after each sample; range 0..15.
- CNT_W, 8, anomaly counter width (only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous active-low reset (0 = reset asserted)
- enable  in  1  1 = streaming allowed; 0 = finish the current sample, then stay in IDLE
- sample_in  in  DATA_W  sensor sample to enqueue
- sample_wr  in  1  push sample_in this cycle; ignored when full
- full  out  1  FIFO holds FIFO_DEPTH entries
- empty  out  1  FIFO holds 0 entries
- overflow  out  1  sticky: a push was attempted while full
- data_input  out  DATA_W  sample presented to i_tree
- data_valid  out  1  data_input is valid
- anomaly_detected  in  1  i_tree result
- anomaly_flag  out  1  sticky: an anomaly was seen
- anomaly_sample  out  DATA_W  value of data_input when the most recent anomaly was seen
- clear  in  1  synchronous clear of overflow, anomaly_flag, anomaly_sample and anomaly_cnt
- anomaly_cnt  out  CNT_W  saturating anomaly count (optional feature only)

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count = 0, empty=1, full=0.
  - FSM = IDLE.
  - data_input=0, data_valid=0.
  - overflow=0, anomaly_flag=0, anomaly_sample=0, anomaly_cnt=0.
  - A reset mid-sample drops data_valid immediately and discards all buffered samples.
- FIFO:
  - Synchronous circular buffer with pointer wrap at FIFO_DEPTH.
  - Push when sample_wr=1 and not full.
  - Pop only on the IDLE->SEND transition.
  - Push and pop in the same cycle: count is unchanged, both pointers advance. When full, a push in the pop cycle is still rejected; full is evaluated before the pop.
  - sample_wr while full: data dropped, overflow<=1.
- FSM (all outputs registered):
  - IDLE: data_valid=0. If enable=1 and not empty: pop, load data_input with the head entry, data_valid<=1, hold counter<=HOLD_CYCLES-1, go to SEND.
  - SEND: data_valid=1 with data_input stable.
    - While hold counter > 0, decrement it.
    - When it reaches 0: data_valid<=0, then go to GAP if GAP_CYCLES>0 (gap counter<=GAP_CYCLES-1), else go to IDLE.
  - GAP: data_valid=0, data_input holds its last value. Decrement the gap counter; at 0 go to IDLE.
- Latency and pacing:
  - A sample pushed into an empty FIFO appears on data_valid 2 cycles later: registered FIFO write, then the IDLE->SEND register.
  - Steady-state period is 1 + HOLD_CYCLES + GAP_CYCLES cycles per sample; the 1 is the IDLE cycle.
- enable=0 in SEND or GAP: the current sample completes normally, then the FSM stays in IDLE.
- Anomaly capture:
  - Anomaly condition: anomaly_detected=1 sampled while FSM is SEND or GAP.
  - On the condition: anomaly_flag<=1, anomaly_sample<=data_input, anomaly_cnt increments, saturating at all-ones.
  - anomaly_detected is ignored in IDLE.
  - clear has priority over a same-cycle anomaly: the flag stays 0 and the count is not incremented.
  - clear does not affect the FIFO or the FSM.

Optional Feature:
- Macro STREAMER_ANOMALY_CNT_EN.
- Defined: the anomaly_cnt port and its CNT_W saturating counter exist.
- Undefined: the anomaly_cnt port and its counter logic are removed. All other behaviour is identical.

Decomposition:
- Package streamer_pkg holds:
  - the FSM state enum (IDLE, SEND, GAP);
  - the default width constants DATA_W and CNT_W;
  - the HOLD/GAP counter width (4 bits).
- One sub-module, sample_fifo, with ports:
  - inputs: clk, reset, wr, wdata, rd;
  - outputs: rdata, full, empty, overflow.
- Pacing FSM and anomaly capture stay in the top module.

Test Plan:
- Single sample: after reset release, push 8'hAB with enable=1 -> data_valid high for exactly 2 cycles carrying 8'hAB, starting 2 cycles after the push; then 1 gap cycle low.
- Back-to-back: push 8'hAB, 8'h23, 8'hAB in consecutive cycles -> three samples emitted in order at a 4-cycle period; empty=1 after the last pop.
- Overflow: push 9 samples with enable=0 (defaults) -> full=1 after 8, overflow=1, 9th sample never emitted; clear -> overflow=0, all 8 entries still emitted after enable=1.
- Anomaly: drive anomaly_detected=1 during the 8'hFF sample -> anomaly_flag=1, anomaly_sample=8'hFF, anomaly_cnt=1; clear in the same cycle as a second anomaly -> flag 0, count 0.
- Reset mid-SEND: assert reset=0 for 5 ns while 8'hAB is on data_valid with 3 entries queued -> data_valid=0 immediately, empty=1, no further samples after release.
- Saturation (macro defined, CNT_W=2): 5 anomalous samples -> anomaly_cnt stays at 3.
